// File: rtl/alu_op_pkg.sv
// Shared ALU op codes and RV32I R-type field constants, used by the
// R-type encoder and decoder. Also holds the encode helper used by the
// encoder's combinational table.
package alu_op_pkg;

    // ALU operation codes (ALU_OP_ENUM encoding)
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_NOP  = 4'd15
    } alu_op_e;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNC3_SLL     = 3'b001;
    localparam logic [2:0] FUNC3_SLT     = 3'b010;
    localparam logic [2:0] FUNC3_SLTU    = 3'b011;
    localparam logic [2:0] FUNC3_XOR     = 3'b100;
    localparam logic [2:0] FUNC3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNC3_OR      = 3'b110;
    localparam logic [2:0] FUNC3_AND     = 3'b111;

    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_result_t;

    // Builds the R-type word; legal=0 for NOP and undefined codes
    function automatic enc_result_t encode_r(input logic [3:0] op,
                                             input logic [4:0] rd,
                                             input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        enc_result_t res;
        logic [2:0]  f3;
        logic [6:0]  f7;
        res.legal = 1'b1;
        f3        = FUNC3_ADD_SUB;
        f7        = FUNC7_BASE;
        case (op)
            ALU_ADD:  f3 = FUNC3_ADD_SUB;
            ALU_SUB:  begin f3 = FUNC3_ADD_SUB; f7 = FUNC7_ALT; end
            ALU_SLL:  f3 = FUNC3_SLL;
            ALU_SLT:  f3 = FUNC3_SLT;
            ALU_SLTU: f3 = FUNC3_SLTU;
            ALU_XOR:  f3 = FUNC3_XOR;
            ALU_SRL:  f3 = FUNC3_SRL_SRA;
            ALU_SRA:  begin f3 = FUNC3_SRL_SRA; f7 = FUNC7_ALT; end
            ALU_OR:   f3 = FUNC3_OR;
            ALU_AND:  f3 = FUNC3_AND;
            default:  res.legal = 1'b0;
        endcase
        res.word = {f7, rs2, rs1, f3, rd, OPCODE_OP};
        return res;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// DEPTH x W output queue for the instruction encoder. Full and empty are
// registered so the input side never sees a combinational path from the
// output side. The head word reads as zero while the queue is empty.
module instr_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // Qualify handshakes against the registered flags and compute next occupancy
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // Storage, wrapping pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
        end
    end

    // Present the head word only while it is valid
    always_comb begin
        head = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/instr_encoder_r.sv
// Streaming RV32I R-type instruction encoder with a DEPTH-entry output FIFO.
// Illegal alu_op tuples are consumed, dropped and flagged on err_illegal.
// Optional statistics counters are enabled by defining INSTR_ENC_STATS_EN.
module instr_encoder_r
    import alu_op_pkg::*;
#(
    parameter int DEPTH = 2
`ifdef INSTR_ENC_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_illegal
`ifdef INSTR_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] drop_count
`endif
);

    enc_result_t enc;
    logic        accept;
    logic        fifo_full;
    logic        fifo_empty;
    logic        emit;

    // Encode table and handshake qualification
    always_comb begin
        enc       = encode_r(in_alu_op, in_rd, in_rs1, in_rs2);
        in_ready  = !fifo_full;
        out_valid = !fifo_empty;
        accept    = in_valid && in_ready;
        emit      = out_valid && out_ready;
    end

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept && enc.legal),
        .push_data (enc.word),
        .pop       (emit),
        .head      (out_instr),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One-cycle pulse after a dropped illegal tuple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !enc.legal;
        end
    end

`ifdef INSTR_ENC_STATS_EN
    // Saturating counts of emitted words and dropped tuples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count  <= '0;
            drop_count <= '0;
        end else begin
            if (emit && (enc_count != '1)) begin
                enc_count <= enc_count + 1'b1;
            end
            if (accept && !enc.legal && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder_r.sv
// Self-checking bench for instr_encoder_r: directed vector table plus
// hand-written sequences for backpressure, drops, streaming, async reset
// and a loopback through a reference R-type decoder. Works with or without
// INSTR_ENC_STATS_EN defined.
module tb_instr_encoder_r;
    import alu_op_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_illegal;
`ifdef INSTR_ENC_STATS_EN
    logic [15:0] enc_count;
    logic [15:0] drop_count;
`endif

    int   checks;
    int   errors;
    int   emit_seen;
    vec_t vecs [10];

    instr_encoder_r #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_op   (in_alu_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .err_illegal (err_illegal)
`ifdef INSTR_ENC_STATS_EN
        ,
        .enc_count   (enc_count),
        .drop_count  (drop_count)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count emit handshakes seen at the active edge
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) emit_seen++;
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid  = 1'b1;
        in_alu_op = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Independent decoder used for the loopback check: returns {op, rd, rs1, rs2}
    function automatic logic [18:0] refDecode(input logic [31:0] w);
        logic [3:0] op;
        case ({w[31:25], w[14:12]})
            10'b0000000_000: op = 4'd0;
            10'b0100000_000: op = 4'd1;
            10'b0000000_001: op = 4'd2;
            10'b0000000_010: op = 4'd3;
            10'b0000000_011: op = 4'd4;
            10'b0000000_100: op = 4'd5;
            10'b0000000_101: op = 4'd6;
            10'b0100000_101: op = 4'd7;
            10'b0000000_110: op = 4'd8;
            10'b0000000_111: op = 4'd9;
            default:         op = 4'd14;
        endcase
        if (w[6:0] != 7'b0110011) op = 4'd13;
        return {op, w[11:7], w[19:15], w[24:20]};
    endfunction

    initial begin
        logic [3:0] rop;
        logic [4:0] rrd, rr1, rr2;

        checks    = 0;
        errors    = 0;
        emit_seen = 0;

        vecs[0] = '{ALU_ADD,  5'd1,  5'd2,  5'd3,  32'h003100B3};
        vecs[1] = '{ALU_SUB,  5'd5,  5'd6,  5'd7,  32'h407302B3};
        vecs[2] = '{ALU_SRA,  5'd31, 5'd31, 5'd31, 32'h41FFDFB3};
        vecs[3] = '{ALU_SLL,  5'd0,  5'd0,  5'd0,  32'h00001033};
        vecs[4] = '{ALU_SLT,  5'd10, 5'd11, 5'd12, 32'h00C5A533};
        vecs[5] = '{ALU_SLTU, 5'd4,  5'd8,  5'd16, 32'h01043233};
        vecs[6] = '{ALU_XOR,  5'd31, 5'd0,  5'd31, 32'h01F04FB3};
        vecs[7] = '{ALU_SRL,  5'd1,  5'd1,  5'd1,  32'h0010D0B3};
        vecs[8] = '{ALU_OR,   5'd2,  5'd3,  5'd4,  32'h0041E133};
        vecs[9] = '{ALU_AND,  5'd7,  5'd7,  5'd7,  32'h0073F3B3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_alu_op = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_instr", out_instr, 32'd0);
        checkOutput("reset_err", 32'(err_illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef INSTR_ENC_STATS_EN
        checkOutput("reset_enc_count", 32'(enc_count), 32'd0);
        checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
`endif

        // Table of single-word encodings with one-cycle latency
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            checkOutput($sformatf("vec%0d_err", i), 32'(err_illegal), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: fill, hold, then drain in order and accept the third
        out_ready = 1'b0;
        applyStimulus(vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2);
        @(negedge clk);
        checkOutput("bp_ready_after1", 32'(in_ready), 32'd1);
        applyStimulus(vecs[1].op, vecs[1].rd, vecs[1].rs1, vecs[1].rs2);
        @(negedge clk);
        checkOutput("bp_ready_full", 32'(in_ready), 32'd0);
        checkOutput("bp_head_first", out_instr, vecs[0].exp);
        applyStimulus(vecs[2].op, vecs[2].rd, vecs[2].rs1, vecs[2].rs2);
        @(negedge clk);
        checkOutput("bp_ready_hold", 32'(in_ready), 32'd0);
        checkOutput("bp_head_hold", out_instr, vecs[0].exp);
        checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_drain_second", out_instr, vecs[1].exp);
        checkOutput("bp_ready_reopen", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_drain_third", out_instr, vecs[2].exp);
        @(negedge clk);
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        // Illegal NOP between two ADDs
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        emit_seen = 0;
        applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        checkOutput("nop_first_word", out_instr, 32'h003100B3);
        applyStimulus(ALU_NOP, 5'd9, 5'd9, 5'd9);
        @(negedge clk);
        checkOutput("nop_err_pulse", 32'(err_illegal), 32'd1);
        checkOutput("nop_not_written", 32'(out_valid), 32'd0);
        applyStimulus(ALU_ADD, 5'd4, 5'd5, 5'd6);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("nop_err_cleared", 32'(err_illegal), 32'd0);
        checkOutput("nop_second_word", out_instr, 32'h00628233);
        @(negedge clk);
        checkOutput("nop_emit_total", 32'(emit_seen), 32'd2);
`ifdef INSTR_ENC_STATS_EN
        checkOutput("nop_drop_count", 32'(drop_count), 32'd1);
        checkOutput("nop_enc_count", 32'(enc_count), 32'd2);
`endif

        // Undefined code 4'd12 is also dropped
        applyStimulus(4'd12, 5'd1, 5'd1, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("undef_err", 32'(err_illegal), 32'd1);
        checkOutput("undef_no_word", 32'(out_valid), 32'd0);

        // Streaming: one word per cycle, in order
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
            @(negedge clk);
            checkOutput($sformatf("stream%0d_instr", i), out_instr, vecs[i].exp);
            checkOutput($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_empty", 32'(out_valid), 32'd0);

        // Async reset while full
        out_ready = 1'b0;
        applyStimulus(vecs[3].op, vecs[3].rd, vecs[3].rs1, vecs[3].rs2);
        @(negedge clk);
        applyStimulus(vecs[4].op, vecs[4].rd, vecs[4].rs1, vecs[4].rs2);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("arst_full_before", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid_now", 32'(out_valid), 32'd0);
        checkOutput("arst_instr_now", out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_ready_after", 32'(in_ready), 32'd1);
        checkOutput("arst_valid_after", 32'(out_valid), 32'd0);
`ifdef INSTR_ENC_STATS_EN
        checkOutput("arst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("arst_drop_count", 32'(drop_count), 32'd0);
`endif
        out_ready = 1'b1;
        applyStimulus(vecs[7].op, vecs[7].rd, vecs[7].rs1, vecs[7].rs2);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("arst_fresh_word", out_instr, vecs[7].exp);
        @(negedge clk);
        checkOutput("arst_no_stale", 32'(out_valid), 32'd0);

        // Loopback through the reference decoder with random legal tuples
        for (int i = 0; i < 16; i++) begin
            rop = 4'($urandom_range(0, 9));
            rrd = 5'($urandom_range(0, 31));
            rr1 = 5'($urandom_range(0, 31));
            rr2 = 5'($urandom_range(0, 31));
            applyStimulus(rop, rrd, rr1, rr2);
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput($sformatf("loop%0d", i), 32'(refDecode(out_instr)),
                        32'({rop, rrd, rr1, rr2}));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
